// File: rtl/simmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simmem_pkg
// Description : Shared constants and types for the simulated-memory bank
//               timing model.
// Revision    : 1.0 - initial release
// ============================================================================
package simmem_pkg;

  localparam int GlobalMemoryCapaWidth = 16;
  localparam int NumBanks              = 4;
  localparam int BankIdxWidth          = $clog2(NumBanks);
  localparam int ClosePage             = 0;
  localparam int IDWidth               = 4;

  // Per-bank lifecycle: waiting for work, counting down cost, holding result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bank_state_e;

endpackage
`default_nettype wire

// File: rtl/simmem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : simmem_rr_arbiter
// Description : Round-robin arbiter with one-hot grant. The grant is frozen
//               while requests are pending and not yet advanced, so the
//               selected requester stays stable under back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module simmem_rr_arbiter #(
  parameter int NumReq = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] i_req,
  input  logic              i_advance,
  output logic [NumReq-1:0] o_gnt
);

  localparam int c_ptr_w = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [c_ptr_w-1:0] r_ptr;
  logic               r_hold;
  logic [NumReq-1:0]  r_held;
  logic [NumReq-1:0]  w_rr;
  logic [c_ptr_w-1:0] w_idx;
  logic [c_ptr_w-1:0] w_gnt_idx;

  // Scan from lowest priority to highest so the highest-priority request wins
  always_comb begin
    w_rr  = '0;
    w_idx = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      w_idx = c_ptr_w'((int'(r_ptr) + k) % NumReq);
      if (i_req[w_idx]) begin
        w_rr        = '0;
        w_rr[w_idx] = 1'b1;
      end
    end
  end

  assign o_gnt = r_hold ? r_held : w_rr;

  // Index of the granted requester, used to move the priority pointer
  always_comb begin
    w_gnt_idx = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (o_gnt[k]) begin
        w_gnt_idx = c_ptr_w'(k);
      end
    end
  end

  // Pointer moves past the winner on advance; otherwise a pending grant is frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_hold <= 1'b0;
      r_held <= '0;
    end else if (i_advance) begin
      r_ptr  <= (w_gnt_idx == c_ptr_w'(NumReq - 1)) ? '0 : w_gnt_idx + 1'b1;
      r_hold <= 1'b0;
    end else begin
      r_hold <= |i_req;
      r_held <= o_gnt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/simmem_bank_timer.sv
`default_nettype none
// ============================================================================
// Module      : simmem_bank_timer
// Description : DRAM bank timing model. Each bank tracks its open row and
//               charges row-hit / activation / precharge costs per access;
//               completions are returned through a round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module simmem_bank_timer
  import simmem_pkg::*;
#(
  parameter int NumBanks          = simmem_pkg::NumBanks,
  parameter int AddrWidth         = GlobalMemoryCapaWidth,
  parameter int RowBufferLenWidth = 8,
  parameter int IDWidth           = simmem_pkg::IDWidth,
  parameter int RowHitCost        = 10,
  parameter int PrechargeCost     = 50,
  parameter int ActivationCost    = 45,
  parameter int ClosePage         = simmem_pkg::ClosePage,
  parameter int LatWidth          = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [IDWidth-1:0]   req_id_i,
  input  logic                 req_is_write_i,
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic [IDWidth-1:0]   done_id_o,
  output logic                 done_is_write_o,
  output logic [LatWidth-1:0]  done_latency_o
);

  localparam int c_bank_bits = $clog2(NumBanks);
  localparam int c_sel_w     = (c_bank_bits > 0) ? c_bank_bits : 1;
  localparam int c_row_lsb   = RowBufferLenWidth + c_bank_bits;
  localparam int c_row_w     = AddrWidth - c_row_lsb;
  localparam int c_max_cost  = PrechargeCost + ActivationCost + RowHitCost;

  localparam logic [LatWidth-1:0] c_cost_hit  = LatWidth'(RowHitCost);
  localparam logic [LatWidth-1:0] c_cost_miss = LatWidth'(ActivationCost + RowHitCost);
  localparam logic [LatWidth-1:0] c_cost_conf = LatWidth'(c_max_cost);

  // Reject parameter sets whose costs cannot be represented or are zero
  if (RowHitCost < 1) begin : g_chk_hit_cost
    $error("simmem_bank_timer: RowHitCost must be at least 1");
  end
  if (c_max_cost > (1 << LatWidth) - 1) begin : g_chk_lat_width
    $error("simmem_bank_timer: worst-case cost does not fit in LatWidth bits");
  end

  logic [c_sel_w-1:0]  w_bank_sel;
  logic [c_row_w-1:0]  w_row;
  logic                w_unused_addr;
  logic                w_accept;
  logic                w_done_hs;
  logic [NumBanks-1:0] w_idle;
  logic [NumBanks-1:0] w_done;
  logic [NumBanks-1:0] w_gnt;
  logic [NumBanks-1:0] w_wr;
  logic [IDWidth-1:0]  w_id  [NumBanks];
  logic [LatWidth-1:0] w_lat [NumBanks];

  if (c_bank_bits > 0) begin : g_sel_multi
    assign w_bank_sel = req_addr_i[RowBufferLenWidth +: c_sel_w];
  end else begin : g_sel_single
    assign w_bank_sel = '0;
  end

  assign w_row         = req_addr_i[AddrWidth-1:c_row_lsb];
  assign w_unused_addr = ^req_addr_i[RowBufferLenWidth-1:0];

  assign req_ready_o = w_idle[w_bank_sel];
  assign w_accept    = req_valid_i & req_ready_o;
  assign done_valid_o = |w_done;
  assign w_done_hs   = done_valid_o & done_ready_i;

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    bank_state_e         r_state;
    logic [c_row_w-1:0]  r_row;
    logic                r_row_vld;
    logic [LatWidth-1:0] r_cnt;
    logic [LatWidth-1:0] r_cost;
    logic [IDWidth-1:0]  r_id;
    logic                r_wr;
    logic                w_sel;
    logic [LatWidth-1:0] w_cost;

    assign w_sel  = w_accept && (w_bank_sel == c_sel_w'(b));
    assign w_cost = !r_row_vld       ? c_cost_miss :
                    (r_row == w_row) ? c_cost_hit  : c_cost_conf;

    // Bank lifecycle: latch request, count down its cost, hold until drained
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state   <= IDLE;
        r_row     <= '0;
        r_row_vld <= 1'b0;
        r_cnt     <= '0;
        r_cost    <= '0;
        r_id      <= '0;
        r_wr      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_sel) begin
              r_state   <= BUSY;
              r_id      <= req_id_i;
              r_wr      <= req_is_write_i;
              r_cost    <= w_cost;
              r_cnt     <= w_cost - 1'b1;
              r_row     <= w_row;
              r_row_vld <= 1'b1;
            end
          end
          BUSY: begin
            if (r_cnt == '0) begin
              r_state <= DONE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          DONE: begin
            if (w_done_hs && w_gnt[b]) begin
              r_state <= IDLE;
              if (ClosePage != 0) begin
                r_row_vld <= 1'b0;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end

    assign w_idle[b] = (r_state == IDLE);
    assign w_done[b] = (r_state == DONE);
    assign w_wr[b]   = r_wr;
    assign w_id[b]   = r_id;
    assign w_lat[b]  = r_cost;
  end

  simmem_rr_arbiter #(
    .NumReq (NumBanks)
  ) u_arb (
    .clk       (clk_i),
    .rst       (rst_i),
    .i_req     (w_done),
    .i_advance (w_done_hs),
    .o_gnt     (w_gnt)
  );

  // AND-OR mux of the granted bank; all zeros when nothing is DONE
  always_comb begin
    done_id_o       = '0;
    done_is_write_o = 1'b0;
    done_latency_o  = '0;
    for (int b = 0; b < NumBanks; b++) begin
      if (w_gnt[b]) begin
        done_id_o       = done_id_o | w_id[b];
        done_is_write_o = done_is_write_o | w_wr[b];
        done_latency_o  = done_latency_o | w_lat[b];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/simmem_bank_timer.md
SIMMEM_BANK_TIMER -- requirements
Module: simmem_bank_timer

Interface
REQ-001 SHALL have parameter NumBanks, default 4, number of independent DRAM banks (power of two, >=1).
REQ-002 SHALL have parameter AddrWidth, default GlobalMemoryCapaWidth (16), request address width.
REQ-003 SHALL have parameter RowBufferLenWidth, default 8, log2 row-buffer length in bytes.
REQ-004 SHALL have parameters RowHitCost, PrechargeCost, ActivationCost, defaults 10, 50, 45, costs in cycles; RowHitCost >= 1.
REQ-005 SHALL have parameter ClosePage, default 0; when 1, every access closes its row on completion.
REQ-006 SHALL have parameter LatWidth, default 8, latency counter and output width.
REQ-007 Ports: clk_i  in  1  clock; one clock; reset is synchronous and active-high.
REQ-008 Port: rst_i  in  1  synchronous active-high reset.
REQ-009 Ports: req_valid_i in 1; req_ready_o out 1; req_addr_i in AddrWidth; req_id_i in IDWidth; req_is_write_i in 1 -- access request.
REQ-010 Ports: done_valid_o out 1; done_ready_i in 1; done_id_o out IDWidth; done_is_write_o out 1; done_latency_o out LatWidth -- completion.

Function
REQ-011 Bank index SHALL be req_addr_i[RowBufferLenWidth +: log2(NumBanks)]; row SHALL be all address bits above the bank index.
REQ-012 Each bank SHALL hold an FSM IDLE -> BUSY -> DONE -> IDLE plus an open-row register and an open-row valid flag.
REQ-013 req_ready_o SHALL be 1 iff the bank addressed by req_addr_i is IDLE; it may depend combinationally on req_addr_i.
REQ-014 Handshake SHALL occur when req_valid_i && req_ready_o; the bank latches id, is_write, cost, enters BUSY.
REQ-015 Cost SHALL be RowHitCost if open row matches, ActivationCost+RowHitCost if no row open, PrechargeCost+ActivationCost+RowHitCost if another row open.
REQ-016 With ClosePage=1 the open-row valid flag SHALL clear on completion, so cost is always ActivationCost+RowHitCost.
REQ-017 Open-row register SHALL update to the request row at acceptance (ClosePage=0).
REQ-018 Accepted at edge t, the bank SHALL enter DONE so that done may be presented at edge t+cost (cost cycles after acceptance).
REQ-019 done_valid_o SHALL be 1 iff any bank is DONE; a round-robin arbiter SHALL select one DONE bank.
REQ-020 Round-robin priority SHALL start at bank 0 after reset and move to granted bank +1 (wrapping at NumBanks) after each done handshake.
REQ-021 done_id_o, done_is_write_o, done_latency_o SHALL be stable while done_valid_o && !done_ready_i; done_latency_o = cost.
REQ-022 On done handshake the granted bank SHALL return to IDLE at the next edge; it is not ready for a new request in the handshake cycle.
REQ-023 Costs exceeding 2^LatWidth-1 SHALL be rejected by an elaboration-time assertion, not truncated.
REQ-024 Different banks SHALL progress independently; one request accepted per cycle; completion and acceptance in the same cycle in different banks SHALL both take effect.

Reset
REQ-025 On rst_i all banks SHALL go IDLE, open-row flags clear, counters zero, arbiter pointer 0, in-flight requests discarded.
REQ-026 During and in the cycle after reset: req_ready_o reflects IDLE banks (1), done_valid_o = 0, done_id_o = 0, done_is_write_o = 0, done_latency_o = 0.

Structure
REQ-027 simmem_pkg SHALL gain NumBanks, BankIdxWidth, ClosePage constants and bank_state_e enum (IDLE, BUSY, DONE).
REQ-028 Round-robin selection SHALL be a sub-module simmem_rr_arbiter (parameter NumReq; req vector in, one-hot grant out, advance input).
REQ-029 Per-bank state SHALL be generated with a generate loop; no per-bank module required.

Verification
REQ-030 Reset, read addr 0x0300 (bank 3, row 0), done_ready_i=1 -> done_valid_o 55 cycles after accept, latency 55, id echoed.
REQ-031 Second access same bank, same row (0x0310) -> latency 10; then 0x4300 (same bank, other row) -> latency 105.
REQ-032 ClosePage=1, three accesses to 0x0300 -> each latency 55.
REQ-033 Banks 0 and 1 reach DONE same cycle, done_ready_i=1 -> bank 0 out first, bank 1 next cycle; pointer then 2.
REQ-034 done_ready_i=0 for 20 cycles with bank 2 DONE -> outputs stable, req_ready_o=0 for bank 2, =1 for bank 0.
REQ-035 rst_i asserted mid-BUSY (cycle 20 of 55) -> done_valid_o never asserts; next same-row access costs 55.
